// File: rtl/baw_game_ctrl.sv
// Black-and-white card game controller: game FSM, button edges, hands, scoring, end of game.
// Optional macro BAW_ALT_LEAD_EN enforces turn order (the loser of the last match leads).
module baw_game_ctrl #(
    parameter int NCARDS = 9,
    parameter int ROUNDS = 9,
    localparam int RW = $clog2(ROUNDS + 1),
    localparam int CW = $clog2(NCARDS + 1),
    localparam int IW = (NCARDS > 1) ? $clog2(NCARDS) : 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              btn_center,
    input  logic              btn_top,
    input  logic              btn_bottom,
    input  logic              btn_left,
    input  logic              btn_right,
    input  logic [NCARDS-1:0] sel,
    output logic [2:0]        state,
    output logic [RW-1:0]     round,
    output logic [RW-1:0]     p1_score,
    output logic [RW-1:0]     p2_score,
    output logic [NCARDS-1:0] p1_hand,
    output logic [NCARDS-1:0] p2_hand,
    output logic [CW-1:0]     p1_black,
    output logic [CW-1:0]     p1_white,
    output logic [CW-1:0]     p2_black,
    output logic [CW-1:0]     p2_white,
    output logic              p1_card_black,
    output logic              p2_card_black,
    output logic [NCARDS-1:0] hand_view,
    output logic [1:0]        match_result,
    output logic [1:0]        game_result,
    output logic              err
);

    typedef enum logic [2:0] {
        S_INIT    = 3'd0,
        S_RASP    = 3'd1,
        S_BAWP    = 3'd2,
        S_P1_TURN = 3'd3,
        S_P2_TURN = 3'd4,
        S_MATCH   = 3'd5,
        S_GAME    = 3'd6
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [4:0]        r_btn_prev;
    logic [4:0]        w_btn;
    logic [4:0]        w_ev;
    logic [RW-1:0]     r_round;
    logic [RW-1:0]     r_p1_score;
    logic [RW-1:0]     r_p2_score;
    logic [NCARDS-1:0] r_p1_hand;
    logic [NCARDS-1:0] r_p2_hand;
    logic              r_p1_played;
    logic              r_p2_played;
    logic [IW-1:0]     r_p1_card;
    logic [IW-1:0]     r_p2_card;
    logic [1:0]        r_match;
    logic              r_err;

    logic              w_finish;
    logic [IW-1:0]     w_sel_idx;
    logic              w_p1_valid;
    logic              w_p2_valid;
    logic              w_p1_may;
    logic              w_p2_may;
    logic              w_reinit;
    logic              w_p1_play;
    logic              w_p2_play;
    logic              w_enter_match;
    logic              w_clear_played;
    logic              w_reject;

    // Bit order {bottom, center, top, left, right} doubles as priority order, MSB first.
    assign w_btn = {btn_bottom, btn_center, btn_top, btn_left, btn_right};
    assign w_ev  = w_btn & ~r_btn_prev;

    assign w_finish = ({1'b0, r_p1_score, 1'b0} > (RW + 2)'(ROUNDS)) ||
                      ({1'b0, r_p2_score, 1'b0} > (RW + 2)'(ROUNDS)) ||
                      (r_round == RW'(ROUNDS));

    always_comb begin
        w_sel_idx = '0;
        for (int i = 0; i < NCARDS; i++) begin
            if (sel[i]) w_sel_idx = IW'(i);
        end
    end

    assign w_p1_valid = $onehot(sel) && ((sel & r_p1_hand) != '0);
    assign w_p2_valid = $onehot(sel) && ((sel & r_p2_hand) != '0);

`ifdef BAW_ALT_LEAD_EN
    logic r_lead;

    // r_lead = 1 means P2 leads; the non-leader may only go once the leader has played.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_lead <= 1'b0;
        end else if (w_reinit) begin
            r_lead <= 1'b0;
        end else if (w_enter_match) begin
            if (r_p1_card > r_p2_card) begin
                r_lead <= 1'b1;
            end else if (r_p2_card > r_p1_card) begin
                r_lead <= 1'b0;
            end
        end
    end

    assign w_p1_may = !r_lead || r_p2_played;
    assign w_p2_may = r_lead || r_p1_played;
`else
    assign w_p1_may = 1'b1;
    assign w_p2_may = 1'b1;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_INIT;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next         = r_state;
        w_reinit       = 1'b0;
        w_p1_play      = 1'b0;
        w_p2_play      = 1'b0;
        w_enter_match  = 1'b0;
        w_clear_played = 1'b0;
        w_reject       = 1'b0;
        if (w_ev[4]) begin
            if (r_state != S_INIT) w_next = S_INIT;
        end else if (w_ev[3]) begin
            if (r_state == S_INIT) begin
                w_next   = S_RASP;
                w_reinit = 1'b1;
            end else if (r_state == S_BAWP) begin
                if (r_p1_played && r_p2_played) begin
                    w_next        = S_MATCH;
                    w_enter_match = 1'b1;
                end else begin
                    w_reject = 1'b1;
                end
            end
        end else if (w_ev[2]) begin
            case (r_state)
                S_RASP: w_next = w_finish ? S_GAME : S_BAWP;
                S_P1_TURN: begin
                    if (w_p1_valid) begin
                        w_next    = S_BAWP;
                        w_p1_play = 1'b1;
                    end else begin
                        w_reject = 1'b1;
                    end
                end
                S_P2_TURN: begin
                    if (w_p2_valid) begin
                        w_next    = S_BAWP;
                        w_p2_play = 1'b1;
                    end else begin
                        w_reject = 1'b1;
                    end
                end
                default: ;
            endcase
        end else if (w_ev[1]) begin
            if (r_state == S_BAWP) begin
                if (!r_p1_played && w_p1_may) w_next = S_P1_TURN;
                else w_reject = 1'b1;
            end else if (r_state == S_MATCH) begin
                w_next         = S_RASP;
                w_clear_played = 1'b1;
            end
        end else if (w_ev[0]) begin
            if (r_state == S_BAWP) begin
                if (!r_p2_played && w_p2_may) w_next = S_P2_TURN;
                else w_reject = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_btn_prev  <= '0;
            r_round     <= '0;
            r_p1_score  <= '0;
            r_p2_score  <= '0;
            r_p1_hand   <= '1;
            r_p2_hand   <= '1;
            r_p1_played <= 1'b0;
            r_p2_played <= 1'b0;
            r_p1_card   <= '0;
            r_p2_card   <= '0;
            r_match     <= 2'b00;
            r_err       <= 1'b0;
        end else begin
            r_btn_prev <= w_btn;
            r_err      <= w_reject;
            if (w_reinit) begin
                r_round     <= '0;
                r_p1_score  <= '0;
                r_p2_score  <= '0;
                r_p1_hand   <= '1;
                r_p2_hand   <= '1;
                r_p1_played <= 1'b0;
                r_p2_played <= 1'b0;
                r_p1_card   <= '0;
                r_p2_card   <= '0;
                r_match     <= 2'b00;
            end
            if (w_p1_play) begin
                r_p1_hand   <= r_p1_hand & ~sel;
                r_p1_card   <= w_sel_idx;
                r_p1_played <= 1'b1;
            end
            if (w_p2_play) begin
                r_p2_hand   <= r_p2_hand & ~sel;
                r_p2_card   <= w_sel_idx;
                r_p2_played <= 1'b1;
            end
            if (w_clear_played) begin
                r_p1_played <= 1'b0;
                r_p2_played <= 1'b0;
            end
            if (w_enter_match) begin
                if (r_round != RW'(ROUNDS)) r_round <= r_round + RW'(1);
                if (r_p1_card > r_p2_card) begin
                    r_match <= 2'b01;
                    if (r_p1_score != RW'(ROUNDS)) r_p1_score <= r_p1_score + RW'(1);
                end else if (r_p2_card > r_p1_card) begin
                    r_match <= 2'b10;
                    if (r_p2_score != RW'(ROUNDS)) r_p2_score <= r_p2_score + RW'(1);
                end else begin
                    r_match <= 2'b11;
                end
            end
        end
    end

    // Odd card values are black, so black cards sit on odd bit positions.
    always_comb begin
        p1_black = '0;
        p1_white = '0;
        p2_black = '0;
        p2_white = '0;
        for (int i = 0; i < NCARDS; i++) begin
            if ((i % 2) == 1) begin
                p1_black = p1_black + CW'(r_p1_hand[i]);
                p2_black = p2_black + CW'(r_p2_hand[i]);
            end else begin
                p1_white = p1_white + CW'(r_p1_hand[i]);
                p2_white = p2_white + CW'(r_p2_hand[i]);
            end
        end
    end

    always_comb begin
        game_result = 2'b00;
        if (w_finish) begin
            if (r_p1_score > r_p2_score) game_result = 2'b01;
            else if (r_p2_score > r_p1_score) game_result = 2'b10;
            else game_result = 2'b11;
        end
    end

    always_comb begin
        hand_view = '0;
        if (r_state == S_P1_TURN) hand_view = r_p1_hand & ~sel;
        else if (r_state == S_P2_TURN) hand_view = r_p2_hand & ~sel;
    end

    assign state         = r_state;
    assign round         = r_round;
    assign p1_score      = r_p1_score;
    assign p2_score      = r_p2_score;
    assign p1_hand       = r_p1_hand;
    assign p2_hand       = r_p2_hand;
    assign p1_card_black = r_p1_card[0];
    assign p2_card_black = r_p2_card[0];
    assign match_result  = r_match;
    assign err           = r_err;

endmodule

// File: tb/tb_baw_game_ctrl.sv
// Self-checking bench for baw_game_ctrl: game-rule reference model compared every cycle,
// directed game script with literal expectations, then randomized button/switch traffic.
`timescale 1ns/1ps
module tb_baw_game_ctrl;

    localparam int NCARDS = 9;
    localparam int ROUNDS = 9;

    localparam int B_RIGHT  = 0;
    localparam int B_LEFT   = 1;
    localparam int B_TOP    = 2;
    localparam int B_CENTER = 3;
    localparam int B_BOTTOM = 4;

    localparam int ST_INIT = 0, ST_RASP = 1, ST_BAWP = 2, ST_P1 = 3, ST_P2 = 4, ST_MATCH = 5, ST_GAME = 6;

`ifdef BAW_ALT_LEAD_EN
    localparam bit ALT = 1'b1;
`else
    localparam bit ALT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn;
    logic [4:0]  btns = '0;
    logic [8:0]  sel = '0;

    logic [2:0]  state;
    logic [3:0]  round, p1_score, p2_score;
    logic [8:0]  p1_hand, p2_hand, hand_view;
    logic [3:0]  p1_black, p1_white, p2_black, p2_white;
    logic        p1_card_black, p2_card_black, err;
    logic [1:0]  match_result, game_result;

    int checks = 0;
    int fails = 0;
    bit cmpEn = 1'b0;

    // Reference model: game state kept as plain integers and card sets
    int       mState, mRound, mS1, mS2, mC1, mC2, mMatch, mLead;
    bit       mPlayed1, mPlayed2, mErr;
    bit [8:0] mHand1, mHand2;
    bit [4:0] mPrev;

    always #5 clk = ~clk;

    baw_game_ctrl #(.NCARDS(NCARDS), .ROUNDS(ROUNDS)) dut (
        .clk(clk), .resetn(resetn),
        .btn_center(btns[B_CENTER]), .btn_top(btns[B_TOP]), .btn_bottom(btns[B_BOTTOM]),
        .btn_left(btns[B_LEFT]), .btn_right(btns[B_RIGHT]), .sel(sel),
        .state(state), .round(round), .p1_score(p1_score), .p2_score(p2_score),
        .p1_hand(p1_hand), .p2_hand(p2_hand),
        .p1_black(p1_black), .p1_white(p1_white), .p2_black(p2_black), .p2_white(p2_white),
        .p1_card_black(p1_card_black), .p2_card_black(p2_card_black),
        .hand_view(hand_view), .match_result(match_result), .game_result(game_result), .err(err)
    );

    task automatic newGame();
        mHand1 = '1; mHand2 = '1;
        mRound = 0; mS1 = 0; mS2 = 0;
        mPlayed1 = 0; mPlayed2 = 0;
        mC1 = 0; mC2 = 0; mMatch = 0; mLead = 1;
    endtask

    task automatic modelReset();
        newGame();
        mState = ST_INIT; mErr = 0; mPrev = '0;
    endtask

    function automatic bit finished();
        return (2 * mS1 > ROUNDS) || (2 * mS2 > ROUNDS) || (mRound == ROUNDS);
    endfunction

    function automatic int gameRes();
        if (!finished()) return 0;
        if (mS1 > mS2) return 1;
        if (mS2 > mS1) return 2;
        return 3;
    endfunction

    function automatic bit mayGo(input int p);
        if (!ALT) return 1'b1;
        return (mLead == p) || ((p == 1) ? mPlayed2 : mPlayed1);
    endfunction

    function automatic int countColour(input bit [8:0] h, input int parity);
        int n = 0;
        for (int i = 0; i < NCARDS; i++) if ((i % 2) == parity && h[i]) n++;
        return n;
    endfunction

    task automatic scoreMatch();
        if (mRound < ROUNDS) mRound++;
        if (mC1 > mC2) begin
            mMatch = 1; mLead = 2;
            if (mS1 < ROUNDS) mS1++;
        end else if (mC2 > mC1) begin
            mMatch = 2; mLead = 1;
            if (mS2 < ROUNDS) mS2++;
        end else begin
            mMatch = 3;
        end
    endtask

    task automatic modelStep(input bit [4:0] b, input bit [8:0] s);
        bit [4:0] ev;
        int n, k;
        ev = b & ~mPrev;
        mPrev = b;
        mErr = 0;
        n = 0; k = 0;
        for (int i = 0; i < NCARDS; i++) if (s[i]) begin n++; k = i; end
        if (ev[B_BOTTOM]) begin
            if (mState != ST_INIT) mState = ST_INIT;
        end else if (ev[B_CENTER]) begin
            if (mState == ST_INIT) begin
                newGame(); mState = ST_RASP;
            end else if (mState == ST_BAWP) begin
                if (mPlayed1 && mPlayed2) begin mState = ST_MATCH; scoreMatch(); end
                else mErr = 1;
            end
        end else if (ev[B_TOP]) begin
            if (mState == ST_RASP) begin
                mState = finished() ? ST_GAME : ST_BAWP;
            end else if (mState == ST_P1) begin
                if (n == 1 && mHand1[k]) begin
                    mHand1[k] = 0; mC1 = k; mPlayed1 = 1; mState = ST_BAWP;
                end else mErr = 1;
            end else if (mState == ST_P2) begin
                if (n == 1 && mHand2[k]) begin
                    mHand2[k] = 0; mC2 = k; mPlayed2 = 1; mState = ST_BAWP;
                end else mErr = 1;
            end
        end else if (ev[B_LEFT]) begin
            if (mState == ST_BAWP) begin
                if (!mPlayed1 && mayGo(1)) mState = ST_P1;
                else mErr = 1;
            end else if (mState == ST_MATCH) begin
                mState = ST_RASP; mPlayed1 = 0; mPlayed2 = 0;
            end
        end else if (ev[B_RIGHT]) begin
            if (mState == ST_BAWP) begin
                if (!mPlayed2 && mayGo(2)) mState = ST_P2;
                else mErr = 1;
            end
        end
    endtask

    always @(posedge clk or negedge resetn) begin
        if (!resetn) modelReset();
        else modelStep(btns, sel);
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic lit(input string name, input logic [31:0] dutVal, input int modelVal, input int want);
        cmp({name, "_dut"}, dutVal, want);
        cmp({name, "_model"}, 32'(modelVal), want);
    endtask

    task automatic checkOutput();
        bit [8:0] view;
        view = '0;
        if (mState == ST_P1) view = mHand1 & ~sel;
        else if (mState == ST_P2) view = mHand2 & ~sel;
        cmp("state", 32'(state), mState);
        cmp("round", 32'(round), mRound);
        cmp("p1_score", 32'(p1_score), mS1);
        cmp("p2_score", 32'(p2_score), mS2);
        cmp("p1_hand", 32'(p1_hand), 32'(mHand1));
        cmp("p2_hand", 32'(p2_hand), 32'(mHand2));
        cmp("p1_black", 32'(p1_black), countColour(mHand1, 1));
        cmp("p1_white", 32'(p1_white), countColour(mHand1, 0));
        cmp("p2_black", 32'(p2_black), countColour(mHand2, 1));
        cmp("p2_white", 32'(p2_white), countColour(mHand2, 0));
        cmp("p1_card_black", 32'(p1_card_black), mC1 % 2);
        cmp("p2_card_black", 32'(p2_card_black), mC2 % 2);
        cmp("hand_view", 32'(hand_view), 32'(view));
        cmp("match_result", 32'(match_result), mMatch);
        cmp("game_result", 32'(game_result), gameRes());
        cmp("err", 32'(err), 32'(mErr));
    endtask

    always @(negedge clk) begin
        if (cmpEn) checkOutput();
    end

    task automatic applyStimulus(input logic [4:0] b, input logic [8:0] s);
        @(posedge clk); #2;
        btns = b; sel = s;
        @(posedge clk); #2;
        btns = '0;
    endtask

    task automatic press(input int b);
        applyStimulus(5'(1 << b), sel);
    endtask

    task automatic playRound(input int a, input int b);
        press(B_TOP);
        if (ALT && mLead == 2) begin
            press(B_RIGHT); applyStimulus(5'(1 << B_TOP), 9'(1 << b));
            press(B_LEFT);  applyStimulus(5'(1 << B_TOP), 9'(1 << a));
        end else begin
            press(B_LEFT);  applyStimulus(5'(1 << B_TOP), 9'(1 << a));
            press(B_RIGHT); applyStimulus(5'(1 << B_TOP), 9'(1 << b));
        end
        press(B_CENTER);
    endtask

    initial begin
        int r;
        int k;
        modelReset();
        resetn = 1'b0;
        #1 cmpEn = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        lit("rst_state", 32'(state), mState, 0);
        lit("rst_p1_hand", 32'(p1_hand), 32'(mHand1), 9'h1FF);
        lit("rst_p2_hand", 32'(p2_hand), 32'(mHand2), 9'h1FF);
        lit("rst_p1_score", 32'(p1_score), mS1, 0);
        lit("rst_p1_black", 32'(p1_black), countColour(mHand1, 1), 4);
        lit("rst_p1_white", 32'(p1_white), countColour(mHand1, 0), 5);
        lit("rst_err", 32'(err), 32'(mErr), 0);
        resetn = 1'b1;

        press(B_CENTER); press(B_TOP); press(B_LEFT);
        applyStimulus(5'(1 << B_TOP), 9'h010);
        press(B_CENTER);
        lit("bawp_one_played_err", 32'(err), 32'(mErr), 1);
        lit("bawp_one_played_state", 32'(state), mState, 2);
        press(B_RIGHT);
        applyStimulus(5'(1 << B_TOP), 9'h004);
        press(B_CENTER);
        lit("r1_state", 32'(state), mState, 5);
        lit("r1_match", 32'(match_result), mMatch, 1);
        lit("r1_p1_score", 32'(p1_score), mS1, 1);
        lit("r1_round", 32'(round), mRound, 1);
        lit("r1_p1_hand", 32'(p1_hand), 32'(mHand1), 9'h1EF);
        lit("r1_p1_white", 32'(p1_white), countColour(mHand1, 0), 4);
        lit("r1_p1_card_black", 32'(p1_card_black), mC1 % 2, 0);

        press(B_LEFT); press(B_TOP);
        if (ALT) begin
            press(B_LEFT);
            lit("alt_left_err", 32'(err), 32'(mErr), 1);
            lit("alt_left_state", 32'(state), mState, 2);
            press(B_RIGHT);
            lit("alt_right_state", 32'(state), mState, 4);
            applyStimulus(5'(1 << B_TOP), 9'h001);
        end
        press(B_LEFT);
        applyStimulus(5'(1 << B_TOP), 9'h011);
        lit("two_hot_err", 32'(err), 32'(mErr), 1);
        lit("two_hot_state", 32'(state), mState, 3);
        lit("two_hot_hand", 32'(p1_hand), 32'(mHand1), 9'h1EF);
        @(posedge clk); #2;
        lit("err_one_cycle", 32'(err), 32'(mErr), 0);
        applyStimulus(5'(1 << B_TOP), 9'h010);
        lit("replayed_err", 32'(err), 32'(mErr), 1);
        lit("replayed_state", 32'(state), mState, 3);
        lit("replayed_hand", 32'(p1_hand), 32'(mHand1), 9'h1EF);
        applyStimulus(5'(1 << B_TOP), 9'h100);
        if (!ALT) begin
            press(B_RIGHT);
            applyStimulus(5'(1 << B_TOP), 9'h001);
        end
        press(B_CENTER);
        lit("r2_p1_score", 32'(p1_score), mS1, 2);
        lit("r2_round", 32'(round), mRound, 2);
        press(B_LEFT);

        playRound(7, 1); press(B_LEFT);
        playRound(6, 3); press(B_LEFT);
        playRound(5, 4);
        lit("r5_p1_score", 32'(p1_score), mS1, 5);
        press(B_LEFT); press(B_TOP);
        lit("game_state", 32'(state), mState, 6);
        lit("game_result", 32'(game_result), gameRes(), 1);
        press(B_TOP);
        lit("game_holds", 32'(state), mState, 6);
        press(B_BOTTOM);
        lit("game_exit", 32'(state), mState, 0);

        press(B_CENTER); press(B_TOP); press(B_LEFT);
        applyStimulus(5'(1 << B_TOP), 9'h002);
        press(B_RIGHT);
        lit("p2_turn_state", 32'(state), mState, 4);
        press(B_BOTTOM);
        lit("abort_state", 32'(state), mState, 0);
        lit("abort_keeps_hand", 32'(p1_hand), 32'(mHand1), 9'h1FD);
        press(B_CENTER);
        lit("restart_state", 32'(state), mState, 1);
        lit("restart_p1_hand", 32'(p1_hand), 32'(mHand1), 9'h1FF);
        lit("restart_p2_hand", 32'(p2_hand), 32'(mHand2), 9'h1FF);
        lit("restart_p1_score", 32'(p1_score), mS1, 0);
        lit("restart_round", 32'(round), mRound, 0);

        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #2;
            r = $urandom_range(0, 99);
            if (r < 40) begin
                btns = '0;
            end else if (r < 55) begin
                btns = btns;
            end else if (r < 95) begin
                k = $urandom_range(0, 19);
                if (k < 5) btns = 5'(1 << B_RIGHT);
                else if (k < 10) btns = 5'(1 << B_LEFT);
                else if (k < 15) btns = 5'(1 << B_TOP);
                else if (k < 19) btns = 5'(1 << B_CENTER);
                else btns = 5'(1 << B_BOTTOM);
            end else begin
                btns = 5'($urandom_range(0, 31));
            end
            if ($urandom_range(0, 2) == 0) begin
                if ($urandom_range(0, 3) != 0) sel = 9'(1 << $urandom_range(0, 8));
                else sel = 9'($urandom_range(0, 511));
            end
            if ($urandom_range(0, 299) == 0) begin
                resetn = 1'b0;
                @(posedge clk); #2;
                resetn = 1'b1;
            end
        end

        @(posedge clk); #2;
        cmpEn = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/baw_game_ctrl.md
# baw_game_ctrl

Parametrised game controller for the black-and-white card game, generalised to NCARDS cards per player and ROUNDS rounds. It owns the game FSM, button edge detection, both players' hands, played-card registers, comparison, scoring and end-of-game detection. It sits between the board buttons and switches and the display and LED logic. It exports state, scores, remaining black/white counts and results for rendering.

## Interface
- NCARDS, 9: cards per player, values 0..NCARDS-1; odd value = black, even = white.
- ROUNDS, 9: rounds per game.
- clk  in  1  system clock.
- resetn  in  1  reset. One clock; reset is asynchronous and active-low.
- btn_center, btn_top, btn_bottom, btn_left, btn_right  in  1 each  button levels, already synchronised.
- sel  in  NCARDS  card-select switches.
- state  out  3  INIT=0, RASP=1, BAWP=2, P1_TURN=3, P2_TURN=4, MATCH=5, GAME=6.
- round  out  $clog2(ROUNDS+1)  completed rounds.
- p1_score, p2_score  out  $clog2(ROUNDS+1)  matches won.
- p1_hand, p2_hand  out  NCARDS  remaining cards, one bit per value.
- p1_black, p1_white, p2_black, p2_white  out  $clog2(NCARDS+1)  popcounts of remaining black/white cards.
- p1_card_black, p2_card_black  out  1  colour of the card played this round.
- hand_view  out  NCARDS  active player's hand & ~sel in P1_TURN/P2_TURN, else 0.
- match_result  out  2  00 none, 01 P1 higher, 10 P2 higher, 11 tie.
- game_result  out  2  00 running, 01 P1, 10 P2, 11 draw.
- err  out  1  one-cycle pulse on a rejected action.

## Operation
- Button event = level & ~previous-level register. Only one event is acted on per cycle. Priority: bottom > center > top > left > right.
- btn_bottom in any state except INIT goes to INIT. No registers are cleared.
- INIT: center goes to RASP and reinitialises the game. Hands become all ones. round, scores, played flags, cards and match_result become 0. The leader becomes P1.
- RASP: top goes to GAME if finish, else BAWP.
- BAWP:
  - left goes to P1_TURN if P1 has not played this round; right goes to P2_TURN likewise. Otherwise err.
  - center goes to MATCH only if both players have played. Otherwise err, stay in BAWP.
- P1_TURN/P2_TURN, on top:
  - Valid selection: sel is one-hot and its bit is set in the player's hand. Then clear that hand bit, store the value (index of the sel bit), set the played flag and go to BAWP.
  - Invalid selection: err, state and hand unchanged.
- Entering MATCH (same edge as BAWP to MATCH):
  - Compare the stored values. The higher value wins and its score increments; equal values give 11 and no score change.
  - round increments.
  - The leader for the next round is updated (see Configuration).
- MATCH: left goes to RASP and clears both played flags.
- GAME: only bottom leaves.
- finish is asserted when 2·p1_score > ROUNDS, or 2·p2_score > ROUNDS, or round == ROUNDS.
- game_result is valid only while finish: the higher score wins; equal scores give 11. It is 00 otherwise.
- Scores and round saturate at ROUNDS.

## Timing
- All state is registered on the clk rising edge. A button event on edge t changes registered outputs after edge t.
- err is high for exactly the cycle following the rejecting edge.
- A held button produces a single event. It must be released for at least one cycle before it re-triggers.
- Popcounts, hand_view, card colours and game_result are combinational from registers and sel; they have no added latency.
- Asynchronous resetn low, including mid-turn:
  - state=INIT; round, scores, cards, played flags, match_result and err = 0.
  - Hands all ones; leader = P1; previous-button registers = 0.
  - At NCARDS=9 this gives p*_black=4 and p*_white=5.
- Release of reset is synchronous to clk.

## Configuration
- BAW_ALT_LEAD_EN defined: the turn order is enforced. In round 1, P1 leads. In later rounds, the loser of the previous match leads; on a tie the leader is unchanged. In BAWP, selecting the non-leader before the leader has played gives err.
- BAW_ALT_LEAD_EN undefined: either player may go first. The leader register is not implemented.

## Test plan
- Reset, then release → state=0, p1_hand=p2_hand=9'h1FF, scores 0, p1_black=4, p1_white=5, err=0.
- Full round:
  - Stimulus: center, top, left; sel=9'h010, top; right; sel=9'h004, top; center.
  - Required response: state=5, match_result=01, p1_score=1, round=1, p1_hand=9'h1EF, p1_white=4, p1_card_black=0.
- P1_TURN with sel=9'h011, or with a card already played, then top → err pulse of 1 cycle, state=3, hand unchanged.
- BAWP with only P1 played, center → err, state stays 2.
- P1 wins 5 matches, then left in MATCH and top in RASP → state=6, game_result=01. Separately, bottom in P2_TURN → state=0, and a following center restores full hands and zero scores.
- BAW_ALT_LEAD_EN defined, round 2 after P1 won round 1 → left in BAWP gives err; right is accepted (state=4).
